// File: rtl/sumador_segmentado_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sumador_pkg : operation codes and NZCV flag type of the pipelined     |
// | adder/subtractor.                              Rev 1.0 - initial      |
// +-----------------------------------------------------------------------+
package sumador_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Subtraction is done as A + ~B + c0, so SUB/SBC invert operand B.
  function automatic logic invierte_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  function automatic logic acarreo_inicial(input op_e op, input logic carry_in);
    logic c0;
    unique case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = carry_in;
    endcase
    return c0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sumador_segmentado_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sumador_segmentado_if : operand/result handshake bus.                 |
// |                                                Rev 1.0 - initial      |
// +-----------------------------------------------------------------------+
interface sumador_segmentado_if #(
  parameter int WIDTH = 32
) ();
  import sumador_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] sumando1;
  logic [WIDTH-1:0] sumando2;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] resultado;
  flags_t           flags;

  modport master (
    output in_valid, op, sumando1, sumando2, carry_in, out_ready,
    input  in_ready, out_valid, resultado, flags
  );

  modport slave (
    input  in_valid, op, sumando1, sumando2, carry_in, out_ready,
    output in_ready, out_valid, resultado, flags
  );

endinterface
`default_nettype wire

// File: rtl/sumador_segmentado_etapa.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sumador_etapa : one pipeline stage, resolves chunk IDX of the sum.    |
// |                                                Rev 1.0 - initial      |
// +-----------------------------------------------------------------------+
module sumador_etapa #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             v_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] r_in,
  input  logic             c_in,
  input  logic             z_in,
  output logic             v_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] r_q,
  output logic             c_q,
  output logic             z_q
);

  localparam int LSB = IDX * CHUNK;

  logic [CHUNK:0]   suma_w;
  logic             carga_w;
  logic             v_d;
  logic             c_d;
  logic             z_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] r_d;

  always_comb begin
    suma_w  = {1'b0, a_in[LSB +: CHUNK]} + {1'b0, b_in[LSB +: CHUNK]}
            + {{CHUNK{1'b0}}, c_in};
    carga_w = adv && v_in;
    v_d     = adv ? v_in : v_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    z_d     = z_q;
    // Data only moves with a real beat so the held output stays put on bubbles.
    if (carga_w) begin
      a_d                = a_in;
      b_d                = b_in;
      r_d                = r_in;
      r_d[LSB +: CHUNK]  = suma_w[CHUNK-1:0];
      c_d                = suma_w[CHUNK];
      z_d                = z_in && (suma_w[CHUNK-1:0] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      c_q <= c_d;
      z_q <= z_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sumador_segmentado.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sumador_segmentado : pipelined WIDTH-bit add/sub with NZCV flags and  |
// | valid/ready flow control.                      Rev 1.0 - initial      |
// +-----------------------------------------------------------------------+
module sumador_segmentado
  import sumador_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sumador_segmentado_if.slave  bus
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int ULT   = STAGES - 1;

  op_e              op_w;
  logic [WIDTH-1:0] b_tr_w;
  logic             c0_w;

  logic [STAGES-1:0] adv_w;
  logic [STAGES-1:0] v_w;
  logic [STAGES-1:0] c_w;
  logic [STAGES-1:0] z_w;
  logic [WIDTH-1:0]  a_w [STAGES];
  logic [WIDTH-1:0]  b_w [STAGES];
  logic [WIDTH-1:0]  r_w [STAGES];

  logic [STAGES-1:0] v_in_w;
  logic [STAGES-1:0] c_in_w;
  logic [STAGES-1:0] z_in_w;
  logic [WIDTH-1:0]  a_in_w [STAGES];
  logic [WIDTH-1:0]  b_in_w [STAGES];
  logic [WIDTH-1:0]  r_in_w [STAGES];

  always_comb begin
    op_w   = op_e'(bus.op);
    b_tr_w = invierte_b(op_w) ? ~bus.sumando2 : bus.sumando2;
    c0_w   = acarreo_inicial(op_w, bus.carry_in);
  end

  // A stage may advance when any stage from it to the output is empty, or the
  // consumer takes the result: this is the advance chain in closed form.
  always_comb begin
    logic lleno;
    lleno = 1'b1;
    adv_w = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      lleno    = lleno && v_w[k];
      adv_w[k] = bus.out_ready || !lleno;
    end
  end

  always_comb begin
    v_in_w[0] = bus.in_valid;
    a_in_w[0] = bus.sumando1;
    b_in_w[0] = b_tr_w;
    r_in_w[0] = '0;
    c_in_w[0] = c0_w;
    z_in_w[0] = 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      v_in_w[k] = v_w[k-1];
      a_in_w[k] = a_w[k-1];
      b_in_w[k] = b_w[k-1];
      r_in_w[k] = r_w[k-1];
      c_in_w[k] = c_w[k-1];
      z_in_w[k] = z_w[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_etapa
    sumador_etapa #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_etapa (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv_w[k]),
      .v_in  (v_in_w[k]),
      .a_in  (a_in_w[k]),
      .b_in  (b_in_w[k]),
      .r_in  (r_in_w[k]),
      .c_in  (c_in_w[k]),
      .z_in  (z_in_w[k]),
      .v_q   (v_w[k]),
      .a_q   (a_w[k]),
      .b_q   (b_w[k]),
      .r_q   (r_w[k]),
      .c_q   (c_w[k]),
      .z_q   (z_w[k])
    );
  end

  assign bus.in_ready  = adv_w[0];
  assign bus.out_valid = v_w[ULT];
  assign bus.resultado = r_w[ULT];
  assign bus.flags     = flags_t'({
                           r_w[ULT][WIDTH-1],
                           z_w[ULT],
                           c_w[ULT],
                           (a_w[ULT][WIDTH-1] == b_w[ULT][WIDTH-1]) &&
                           (r_w[ULT][WIDTH-1] != a_w[ULT][WIDTH-1])
                         });

  // Only the operand sign bits matter once every chunk has been summed.
  logic unused_w;
  assign unused_w = ^{a_w[ULT][WIDTH-2:0], b_w[ULT][WIDTH-2:0]};

endmodule
`default_nettype wire

// File: tb/tb_sumador_segmentado.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sumador_segmentado : randomized bench with arithmetic reference.   |
// |                                                Rev 1.0 - initial      |
// +-----------------------------------------------------------------------+
module tb_sumador_segmentado;
  import sumador_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } beat_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
  } esp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sumador_segmentado_if #(.WIDTH(WIDTH)) bus ();

  sumador_segmentado #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: signed/unsigned integer arithmetic on 64-bit values.
  function automatic esp_t modelo(input beat_t x);
    esp_t   e;
    longint ua, ub, sa, sb, cl, full, sfull;
    logic   resta, cf;
    ua = longint'(x.a);
    ub = longint'(x.b);
    sa = longint'($signed(x.a));
    sb = longint'($signed(x.b));
    case (x.op)
      2'b00:   begin resta = 1'b0; cl = 0; end
      2'b01:   begin resta = 1'b1; cl = 1; end
      2'b10:   begin resta = 1'b0; cl = longint'(x.cin); end
      default: begin resta = 1'b1; cl = longint'(x.cin); end
    endcase
    if (resta) begin
      full  = ua - ub - (1 - cl);
      sfull = sa - sb - (1 - cl);
      cf    = (full >= 0);
    end else begin
      full  = ua + ub + cl;
      sfull = sa + sb + cl;
      cf    = (full >= 64'sh1_0000_0000);
    end
    e.res = full[31:0];
    e.fl  = {e.res[31], (e.res == 32'h0), cf,
             (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648)};
    return e;
  endfunction

  function automatic beat_t beat_aleatorio();
    beat_t       x;
    logic [31:0] esq [4];
    esq[0] = 32'h0000_0000;
    esq[1] = 32'hFFFF_FFFF;
    esq[2] = 32'h7FFF_FFFF;
    esq[3] = 32'h8000_0000;
    x.op  = 2'($urandom_range(0, 3));
    x.cin = 1'($urandom_range(0, 1));
    x.a   = ($urandom_range(0, 3) == 0) ? esq[$urandom_range(0, 3)] : $urandom();
    x.b   = ($urandom_range(0, 3) == 0) ? esq[$urandom_range(0, 3)] : $urandom();
    return x;
  endfunction

  task automatic poner(input beat_t x, input logic v);
    bus.in_valid = v;
    bus.op       = x.op;
    bus.sumando1 = x.a;
    bus.sumando2 = x.b;
    bus.carry_in = x.cin;
  endtask

  task automatic test_reset();
    poner('0, 1'b0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    compared++;
    if ({bus.out_valid, bus.resultado, bus.flags} !== 37'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got valid=%b res=%h flags=%b, want 0/0/0",
               bus.out_valid, bus.resultado, bus.flags);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    beat_t       tv [8];
    logic [31:0] er [8];
    logic [3:0]  ef [8];
    int          lat;
    tv[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0}; er[0] = 32'h0000_0000; ef[0] = 4'b0110;
    tv[1] = '{2'b01, 32'h0000_0005, 32'h0000_0007, 1'b0}; er[1] = 32'hFFFF_FFFE; ef[1] = 4'b1000;
    tv[2] = '{2'b01, 32'h0000_0007, 32'h0000_0005, 1'b0}; er[2] = 32'h0000_0002; ef[2] = 4'b0010;
    tv[3] = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0}; er[3] = 32'h8000_0000; ef[3] = 4'b1001;
    tv[4] = '{2'b10, 32'h0000_00FF, 32'h0000_0000, 1'b1}; er[4] = 32'h0000_0100; ef[4] = 4'b0000;
    tv[5] = '{2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0}; er[5] = 32'h0000_0001; ef[5] = 4'b0010;
    tv[6] = '{2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b1}; er[6] = 32'h0001_0000; ef[6] = 4'b0000;
    tv[7] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0}; er[7] = 32'h7FFF_FFFF; ef[7] = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      poner(tv[i], 1'b1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      compared++;
      if (bus.in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      compared++;
      if (lat != STAGES) begin
        mismatched++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, STAGES);
      end
      compared++;
      if (bus.resultado !== er[i] || bus.flags !== ef[i]) begin
        mismatched++;
        $display("FAIL dir%0d_result: got %h/%b want %h/%b",
                 i, bus.resultado, bus.flags, er[i], ef[i]);
      end
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL dir%0d_drained: got out_valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_stall();
    beat_t       bt [8];
    int          acc = 0, emi = 0, cyc = 0;
    logic        stalled = 1'b0;
    logic [31:0] pres = '0;
    logic [3:0]  pfl = '0;
    esp_t        e;
    for (int i = 0; i < 8; i++) begin
      bt[i] = beat_aleatorio();
      bt[i].a[3:0] = 4'(i);
    end
    while (emi < 8 && cyc < 100) begin
      @(posedge clk); #1;
      bus.out_ready = (cyc >= 6);
      if (acc < 8) poner(bt[acc], 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (stalled) begin
        compared++;
        if ({bus.out_valid, bus.resultado, bus.flags} !== {1'b1, pres, pfl}) begin
          mismatched++;
          $display("FAIL stall_hold: got %b/%h/%b want 1/%h/%b",
                   bus.out_valid, bus.resultado, bus.flags, pres, pfl);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      pres = bus.resultado;
      pfl  = bus.flags;
      if (!bus.out_ready && acc >= STAGES) begin
        compared++;
        if (bus.in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_full_in_ready: cycle %0d got %b want 0", cyc, bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        e = modelo(bt[emi]);
        compared++;
        if (bus.resultado !== e.res || bus.flags !== e.fl) begin
          mismatched++;
          $display("FAIL stall_beat%0d: got %h/%b want %h/%b",
                   emi, bus.resultado, bus.flags, e.res, e.fl);
        end
        emi++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      cyc++;
    end
    compared++;
    if (emi != 8 || acc != 8) begin
      mismatched++;
      $display("FAIL stall_count: got accepted=%0d emitted=%0d want 8/8", acc, emi);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_no_dup: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_alterna();
    esp_t  q [$];
    esp_t  e;
    beat_t cur;
    int    acc = 0, emi = 0, cyc = 0, primero = -1, ultimo = -1;
    cur = beat_aleatorio();
    while (emi < 10 && cyc < 200) begin
      @(posedge clk); #1;
      bus.out_ready = (cyc % 2 == 0);
      poner(cur, acc < 10);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL alt_extra: got unexpected result %h want none", bus.resultado);
        end else begin
          e = q.pop_front();
          if (bus.resultado !== e.res || bus.flags !== e.fl) begin
            mismatched++;
            $display("FAIL alt_beat%0d: got %h/%b want %h/%b",
                     emi, bus.resultado, bus.flags, e.res, e.fl);
          end
        end
        if (primero < 0) primero = cyc;
        ultimo = cyc;
        emi++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(modelo(cur));
        acc++;
        cur = beat_aleatorio();
      end
      cyc++;
    end
    compared++;
    if (emi != 10 || (ultimo - primero) != 18) begin
      mismatched++;
      $display("FAIL alt_rate: got emitted=%0d span=%0d want 10/18", emi, ultimo - primero);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random();
    esp_t        q [$];
    esp_t        e;
    beat_t       cur = '0;
    logic        pend = 1'b0, stalled = 1'b0;
    logic [31:0] pres = '0;
    logic [3:0]  pfl = '0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 400) begin
        if (!pend) begin
          pend = ($urandom_range(0, 3) != 0);
          cur  = beat_aleatorio();
        end
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        pend = 1'b0;
        bus.out_ready = 1'b1;
      end
      poner(cur, pend);
      @(negedge clk);
      if (stalled) begin
        compared++;
        if ({bus.out_valid, bus.resultado, bus.flags} !== {1'b1, pres, pfl}) begin
          mismatched++;
          $display("FAIL rnd_hold: cycle %0d got %b/%h/%b want 1/%h/%b",
                   cyc, bus.out_valid, bus.resultado, bus.flags, pres, pfl);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      pres = bus.resultado;
      pfl  = bus.flags;
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL rnd_extra: got unexpected result %h want none", bus.resultado);
        end else begin
          e = q.pop_front();
          if (bus.resultado !== e.res || bus.flags !== e.fl) begin
            mismatched++;
            $display("FAIL rnd_beat: cycle %0d got %h/%b want %h/%b",
                     cyc, bus.resultado, bus.flags, e.res, e.fl);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(modelo(cur));
        pend = 1'b0;
      end
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL rnd_lost: got %0d beats outstanding want 0", q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      poner(beat_aleatorio(), 1'b1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.out_valid, bus.resultado, bus.flags} !== 37'h0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got valid=%b res=%h flags=%b, want 0/0/0",
               bus.out_valid, bus.resultado, bus.flags);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    poner('{2'b00, 32'h2, 32'h3, 1'b0}, 1'b1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    compared++;
    if (lat != STAGES || bus.resultado !== 32'h5 || bus.flags !== 4'b0000) begin
      mismatched++;
      $display("FAIL midreset_new_beat: got lat=%0d res=%h flags=%b want %0d/00000005/0000",
               lat, bus.resultado, bus.flags, STAGES);
    end
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_stale: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_alterna();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
